// File: rtl/cmd_link_dec.sv
// Command-link receiver: SECDED decode of each codeword, registered command unpack,
// consecutive-error tracking and OK/DEGRADED/LOST link supervision.
module cmd_link_dec #(
    parameter int unsigned CMD_L     = 4,
    parameter int unsigned MODE_L    = 2,
    parameter int unsigned SAFE_MODE = 0,
    parameter int unsigned ERR_W     = 4,
    parameter int unsigned ERR_THR   = 8,
    parameter int unsigned REC_CNT   = 4,
    parameter int unsigned TIMEOUT   = 1000,
    localparam int unsigned K = 2 * CMD_L + MODE_L,
    localparam int unsigned P = (K + 2 <= 2)  ? 1 :
                                (K + 3 <= 4)  ? 2 :
                                (K + 4 <= 8)  ? 3 :
                                (K + 5 <= 16) ? 4 :
                                (K + 6 <= 32) ? 5 :
                                (K + 7 <= 64) ? 6 :
                                (K + 8 <= 128) ? 7 : 8,
    localparam int unsigned N      = K + P,
    localparam int unsigned DATA_L = N + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avl,
    input  logic [DATA_L-1:0] data,
    input  logic              clr_fault,
    output logic [MODE_L-1:0] mode,
    output logic [CMD_L-1:0]  speed_cmd,
    output logic [CMD_L-1:0]  dir_cmd,
    output logic              cmd_vld,
    output logic              corr,
    output logic              uncorr,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        link_state
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(REC_CNT + 1);

    typedef enum logic [1:0] {
        StOk   = 2'd0,
        StDeg  = 2'd1,
        StLost = 2'd2
    } link_st_e;

    // Positions covered by syndrome bit b: every Hamming index with bit b set.
    function automatic logic [DATA_L-1:0] syn_mask(input int unsigned b);
        logic [DATA_L-1:0] m;
        m = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            if (((i >> b) & 1) != 0) m = m | (DATA_L'(1) << i);
        end
        return m;
    endfunction

    // Hamming position of payload bit j (non-power-of-two slots, ascending).
    function automatic int unsigned pay_pos(input int unsigned j);
        int unsigned pos;
        int unsigned cnt;
        pos = 0;
        cnt = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == j) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic              v1_q;
    logic [DATA_L-1:0] data1_q;
    logic [P-1:0]      syn;
    logic              par;
    logic              is_clean, is_corr, is_uncorr, is_bad, usable;
    logic [DATA_L-1:0] cw;
    logic [K-1:0]      pay;
    logic              timeout;

    link_st_e          st_q, st_d;
    logic [ERR_W-1:0]  err_d;
    logic [RW-1:0]     rec_q, rec_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [MODE_L-1:0] mode_d;
    logic [CMD_L-1:0]  speed_d, dir_d;

    for (genvar b = 0; b < P; b++) begin : g_syn
        assign syn[b] = ^(data1_q & syn_mask(b));
    end

    assign par       = ^data1_q;
    assign is_clean  = v1_q && (syn == '0) && !par;
    assign is_corr   = v1_q && par && (32'(syn) <= N);
    assign is_uncorr = v1_q && !is_clean && !is_corr;
    assign is_bad    = is_corr || is_uncorr;
    assign usable    = is_clean || is_corr;
    // Syndrome 0 with odd parity means only the overall parity bit flipped.
    assign cw        = data1_q ^ (is_corr ? (DATA_L'(1) << syn) : '0);

    for (genvar j = 0; j < K; j++) begin : g_pay
        assign pay[j] = cw[pay_pos(j)];
    end

    assign timeout    = !avl && (timer_q == TW'(TIMEOUT - 1));
    assign link_state = st_q;

    always_comb begin
        st_d    = st_q;
        err_d   = err_cnt;
        rec_d   = rec_q;
        mode_d  = mode;
        speed_d = speed_cmd;
        dir_d   = dir_cmd;

        if (avl) begin
            timer_d = '0;
        end else if (timer_q != TW'(TIMEOUT)) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        if (is_clean) begin
            err_d = '0;
        end else if (is_bad && (err_cnt != '1)) begin
            err_d = err_cnt + 1'b1;
        end

        case (st_q)
            StOk: begin
                if (is_bad && (32'(err_d) >= ERR_THR)) begin
                    st_d  = StDeg;
                    rec_d = '0;
                end
            end
            StDeg: begin
                if (is_clean) begin
                    if (32'(rec_q) + 1 >= REC_CNT) begin
                        st_d  = StOk;
                        rec_d = '0;
                    end else begin
                        rec_d = rec_q + 1'b1;
                    end
                end else if (is_bad) begin
                    rec_d = '0;
                end
            end
            default: begin
                if (usable) st_d = StOk;
            end
        endcase

        if (clr_fault && (st_q != StLost)) begin
            st_d  = StOk;
            err_d = '0;
            rec_d = '0;
        end

        if (timeout && (st_q != StLost)) begin
            st_d  = StLost;
            rec_d = '0;
        end

        if (usable) begin
            mode_d  = pay[MODE_L-1:0];
            speed_d = pay[MODE_L +: CMD_L];
            dir_d   = pay[MODE_L+CMD_L +: CMD_L];
        end
        // Safety overrides follow the state the link lands in after this cycle.
        if (st_d == StDeg) begin
            speed_d = '0;
            mode_d  = MODE_L'(SAFE_MODE);
        end else if (st_d == StLost) begin
            speed_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            data1_q   <= '0;
            st_q      <= StLost;
            err_cnt   <= '0;
            rec_q     <= '0;
            timer_q   <= '0;
            mode      <= '0;
            speed_cmd <= '0;
            dir_cmd   <= '0;
            cmd_vld   <= 1'b0;
            corr      <= 1'b0;
            uncorr    <= 1'b0;
        end else begin
            v1_q <= avl;
            if (avl) data1_q <= data;
            st_q      <= st_d;
            err_cnt   <= err_d;
            rec_q     <= rec_d;
            timer_q   <= timer_d;
            mode      <= mode_d;
            speed_cmd <= speed_d;
            dir_cmd   <= dir_d;
            cmd_vld   <= usable;
            corr      <= is_corr;
            uncorr    <= is_uncorr;
        end
    end

endmodule

// File: tb/tb_cmd_link_dec.sv
// Randomised scoreboard bench for cmd_link_dec: a spec-level link model predicts every
// decoded response and link state; a monitor checks responses at their due cycle.
module tb_cmd_link_dec;

    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        avl = 1'b0;
    logic [14:0] data = '0;
    logic        clr_fault = 1'b0;
    logic [1:0]  mode;
    logic [3:0]  speed_cmd, dir_cmd, err_cnt;
    logic        cmd_vld, corr, uncorr;
    logic [1:0]  link_state;

    cmd_link_dec dut (
        .clk        (clk),
        .rst        (rst),
        .avl        (avl),
        .data       (data),
        .clr_fault  (clr_fault),
        .mode       (mode),
        .speed_cmd  (speed_cmd),
        .dir_cmd    (dir_cmd),
        .cmd_vld    (cmd_vld),
        .corr       (corr),
        .uncorr     (uncorr),
        .err_cnt    (err_cnt),
        .link_state (link_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         due;
        logic       vld;
        logic       cor;
        logic       unc;
        logic [1:0] mode;
        logic [3:0] spd;
        logic [3:0] dir;
        logic [3:0] err;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    // Link model: state 0=OK 1=DEGRADED 2=LOST.
    int         m_st, m_err, m_rec, m_idle;
    logic [1:0] m_mode;
    logic [3:0] m_spd, m_dir;

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            total++;
            if ({cmd_vld, corr, uncorr, mode, speed_cmd, dir_cmd, err_cnt, link_state} !==
                {mon_e.vld, mon_e.cor, mon_e.unc, mon_e.mode, mon_e.spd, mon_e.dir, mon_e.err,
                 mon_e.st}) begin
                bad++;
                $display("FAIL resp cyc=%0d got vld=%b corr=%b unc=%b mode=%0d spd=%0d dir=%0d err=%0d st=%0d want vld=%b corr=%b unc=%b mode=%0d spd=%0d dir=%0d err=%0d st=%0d",
                         cyc, cmd_vld, corr, uncorr, mode, speed_cmd, dir_cmd, err_cnt,
                         link_state, mon_e.vld, mon_e.cor, mon_e.unc, mon_e.mode, mon_e.spd,
                         mon_e.dir, mon_e.err, mon_e.st);
            end
        end else if (cmd_vld || corr || uncorr) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse cyc=%0d got vld=%b corr=%b unc=%b want none",
                     cyc, cmd_vld, corr, uncorr);
        end
    end

    function automatic logic [14:0] encode(input logic [9:0] pay);
        logic [14:0] cw;
        logic        b;
        int          j;
        cw = '0;
        j  = 0;
        for (int i = 1; i <= 14; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (pay[j]) cw = cw | (15'(1) << i);
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            b = 1'b0;
            for (int i = 1; i <= 14; i++) begin
                if (((i >> k) & 1) != 0) b = b ^ cw[i];
            end
            if (b) cw = cw | (15'(1) << (1 << k));
        end
        if (^cw) cw = cw | 15'(1);
        return cw;
    endfunction

    task automatic model_reset();
        m_st   = 2;
        m_err  = 0;
        m_rec  = 0;
        m_idle = 0;
        m_mode = '0;
        m_spd  = '0;
        m_dir  = '0;
        exp_q.delete();
    endtask

    task automatic tick_idle();
        m_idle++;
        if (m_idle == TIMEOUT && m_st != 2) begin
            m_st  = 2;
            m_spd = '0;
            m_rec = 0;
        end
    endtask

    // kind: 0 clean, 1 single-bit error, 2 double-bit error.
    task automatic model_frame(input int kind, input logic [9:0] pay, input bit clr,
                               input int due);
        int   st0;
        exp_t e;
        st0    = m_st;
        m_idle = 0;
        if (kind == 0) m_err = 0;
        else if (m_err < 15) m_err++;
        if (m_st == 0) begin
            if (kind != 0 && m_err >= 8) begin
                m_st  = 1;
                m_rec = 0;
            end
        end else if (m_st == 1) begin
            if (kind == 0) begin
                m_rec++;
                if (m_rec >= 4) begin
                    m_st  = 0;
                    m_rec = 0;
                end
            end else begin
                m_rec = 0;
            end
        end else if (kind != 2) begin
            m_st = 0;
        end
        if (clr && st0 != 2) begin
            m_st  = 0;
            m_err = 0;
            m_rec = 0;
        end
        if (kind != 2) begin
            m_mode = pay[1:0];
            m_spd  = pay[5:2];
            m_dir  = pay[9:6];
        end
        if (m_st == 1) begin
            m_spd  = '0;
            m_mode = '0;
        end else if (m_st == 2) begin
            m_spd = '0;
        end
        e.due  = due;
        e.vld  = (kind != 2);
        e.cor  = (kind == 1);
        e.unc  = (kind == 2);
        e.mode = m_mode;
        e.spd  = m_spd;
        e.dir  = m_dir;
        e.err  = 4'(m_err);
        e.st   = 2'(m_st);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [9:0] pay, input int f1, input int f2, input bit clr);
        logic [14:0] cw;
        int          kind;
        cw   = encode(pay);
        kind = 0;
        if (f1 >= 0) begin
            cw   = cw ^ (15'(1) << f1);
            kind = 1;
        end
        if (f2 >= 0) begin
            cw   = cw ^ (15'(1) << f2);
            kind = 2;
        end
        @(posedge clk);
        #1;
        avl       = 1'b1;
        data      = cw;
        clr_fault = 1'b0;
        model_frame(kind, pay, clr, cyc + 2);
        if (clr) begin
            @(posedge clk);
            #1;
            avl       = 1'b0;
            clr_fault = 1'b1;
            tick_idle();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            avl       = 1'b0;
            clr_fault = 1'b0;
            tick_idle();
        end
    endtask

    task automatic check_state(input string name);
        idle(2);
        @(posedge clk);
        #1;
        avl       = 1'b0;
        clr_fault = 1'b0;
        @(negedge clk);
        total++;
        if ({link_state, err_cnt, mode, speed_cmd, dir_cmd} !==
            {2'(m_st), 4'(m_err), m_mode, m_spd, m_dir}) begin
            bad++;
            $display("FAIL %s got st=%0d err=%0d mode=%0d spd=%0d dir=%0d want st=%0d err=%0d mode=%0d spd=%0d dir=%0d",
                     name, link_state, err_cnt, mode, speed_cmd, dir_cmd, m_st, m_err, m_mode,
                     m_spd, m_dir);
        end
        tick_idle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        avl       = 1'b0;
        clr_fault = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick_idle();
    endtask

    logic [9:0] pay;
    int         r, f1, f2;

    initial begin
        model_reset();
        do_reset();
        check_state("reset_state");

        // mode=2 speed=5 dir=9, LOST -> OK
        send({4'd9, 4'd5, 2'd2}, -1, -1, 1'b0);
        check_state("first_clean");

        send({4'd3, 4'd7, 2'd1}, 6, -1, 1'b0);
        send({4'd4, 4'd2, 2'd3}, -1, -1, 1'b0);
        send({4'd1, 4'd8, 2'd0}, 3, 5, 1'b0);
        send({4'd6, 4'd11, 2'd2}, 0, -1, 1'b0);
        check_state("corr_uncorr");

        for (int i = 0; i < 8; i++) send(10'($urandom), $urandom_range(14), -1, 1'b0);
        check_state("enter_degraded");
        for (int i = 0; i < 4; i++) send(10'($urandom), -1, -1, 1'b0);
        check_state("recover_ok");

        for (int i = 0; i < 8; i++) send(10'($urandom), $urandom_range(14), -1, 1'b0);
        send({4'd5, 4'd9, 2'd3}, 7, -1, 1'b1);
        check_state("clr_with_bad");

        idle(TIMEOUT);
        check_state("timeout_lost");
        send({4'd2, 4'd12, 2'd1}, -1, -1, 1'b0);
        idle(TIMEOUT - 1);
        send({4'd10, 4'd3, 2'd2}, -1, -1, 1'b0);
        check_state("avl_on_timeout");

        @(posedge clk);
        #1;
        avl  = 1'b1;
        data = encode({4'd7, 4'd7, 2'd1});
        @(posedge clk);
        #1;
        avl = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick_idle();
        check_state("reset_midflight");

        send({4'd1, 4'd1, 2'd1}, -1, -1, 1'b0);
        for (int i = 0; i < 20; i++) send(10'($urandom), $urandom_range(14), -1, 1'b0);
        check_state("err_saturate");

        for (int n = 0; n < 400; n++) begin
            r   = $urandom_range(99);
            pay = 10'($urandom);
            f1  = -1;
            f2  = -1;
            if (r >= 60) f1 = $urandom_range(14);
            if (r >= 85) f2 = (f1 + 1 + $urandom_range(13)) % 15;
            send(pay, f1, f2, ($urandom_range(19) == 0));
            if ($urandom_range(1) == 0) idle($urandom_range(3));
        end
        check_state("random_end");

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drained got pending=%0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
